// File: rtl/st7735s_spi_rx.sv
// ST7735S 4-wire SPI receiver (LCD side).
// Oversamples SCK/MOSI/DC/SS on i_clk, deserializes MSB-first bytes in mode 0,
// tags each byte as command or data and tracks the parameter index after the
// most recent command.
module st7735s_spi_rx #(
  parameter int c_SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_spi_clk,
  input  logic       i_spi_mosi,
  input  logic       i_spi_dc,
  input  logic       i_spi_ss,
  output logic [7:0] o_data,
  output logic       o_ncommand,
  output logic       o_data_valid,
  output logic [7:0] o_cmd,
  output logic [3:0] o_param_idx,
  output logic       o_frame_err,
  output logic       o_busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                   state;
  logic [c_SYNC_STAGES-1:0] sck_sync;
  logic [c_SYNC_STAGES-1:0] ss_sync;
  logic [c_SYNC_STAGES-1:0] mosi_sync;
  logic [c_SYNC_STAGES-1:0] dc_sync;
  logic                     sck_d;
  logic                     ss_d;
  logic                     sck_rise_q;
  logic                     ss_rise_q;
  logic                     ss_fall_q;
  logic [7:0]               shift_reg;
  logic [2:0]               bit_cnt;
  logic [2:0]               bit_cnt_nxt;
  logic [3:0]               param_cnt;
  logic                     sck_s;
  logic                     ss_s;
  logic                     mosi_s;
  logic                     dc_s;

  assign sck_s  = sck_sync[c_SYNC_STAGES-1];
  assign ss_s   = ss_sync[c_SYNC_STAGES-1];
  assign mosi_s = mosi_sync[c_SYNC_STAGES-1];
  assign dc_s   = dc_sync[c_SYNC_STAGES-1];
  assign o_busy = ~ss_s;

  // Input synchronizers, edge-detect flops and registered edge pulses.
  // SS edges are registered alongside the SCK edge so that an SS release and
  // the 8th SCK edge arriving together at the pins are seen in the same cycle.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sck_sync   <= '0;
      ss_sync    <= '1;
      mosi_sync  <= '0;
      dc_sync    <= '0;
      sck_d      <= 1'b0;
      ss_d       <= 1'b1;
      sck_rise_q <= 1'b0;
      ss_rise_q  <= 1'b0;
      ss_fall_q  <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[c_SYNC_STAGES-2:0], i_spi_clk};
      ss_sync    <= {ss_sync[c_SYNC_STAGES-2:0], i_spi_ss};
      mosi_sync  <= {mosi_sync[c_SYNC_STAGES-2:0], i_spi_mosi};
      dc_sync    <= {dc_sync[c_SYNC_STAGES-2:0], i_spi_dc};
      sck_d      <= sck_s;
      ss_d       <= ss_s;
      sck_rise_q <= sck_s & ~sck_d;
      ss_rise_q  <= ss_s & ~ss_d;
      ss_fall_q  <= ~ss_s & ss_d;
    end
  end

  // Bit count after the current cycle's SCK edge (wraps to 0 on byte completion).
  always_comb begin
    bit_cnt_nxt = bit_cnt;
    if (sck_rise_q) begin
      bit_cnt_nxt = bit_cnt + 3'd1;
    end
  end

  // Receive FSM: deserialize bytes while SS is low, publish results as pulses.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      param_cnt    <= '0;
      o_data       <= '0;
      o_ncommand   <= 1'b0;
      o_data_valid <= 1'b0;
      o_cmd        <= '0;
      o_param_idx  <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall_q) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end
        SHIFT: begin
          if (sck_rise_q) begin
            shift_reg <= {shift_reg[6:0], mosi_s};
            bit_cnt   <= bit_cnt_nxt;
            if (bit_cnt == 3'd7) begin
              o_data       <= {shift_reg[6:0], mosi_s};
              o_ncommand   <= dc_s;
              o_data_valid <= 1'b1;
              if (!dc_s) begin
                o_cmd       <= {shift_reg[6:0], mosi_s};
                param_cnt   <= '0;
                o_param_idx <= '0;
              end else begin
                o_param_idx <= param_cnt;
                if (param_cnt != 4'd15) begin
                  param_cnt <= param_cnt + 4'd1;
                end
              end
            end
          end
          if (ss_rise_q) begin
            state <= IDLE;
            if (bit_cnt_nxt != 3'd0) begin
              o_frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
